// File: rtl/lcd_link_pkg.sv
// Shared LCD link constants and receiver state encoding for the SPI ingest and HDP streamer.
package lcd_link_pkg;

  localparam int LINE_WORDS  = 40;
  localparam int WORD_BITS   = 32;
  localparam int LINE_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } rxState_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer chain plus rise/fall detect for one asynchronous input; STAGES cycles to o_level.
// Edge outputs are single-cycle pulses; no backpressure.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] chain;
  logic              prevLevel;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      chain     <= '0;
      prevLevel <= 1'b0;
    end else begin
      chain     <= {chain[STAGES-2:0], i_async};
      prevLevel <= chain[STAGES-1];
    end
  end

  assign o_level = chain[STAGES-1];
  assign o_rise  = chain[STAGES-1] & ~prevLevel;
  assign o_fall  = ~chain[STAGES-1] & prevLevel;

endmodule

// File: rtl/spi_line_ingest.sv
// SPI line receiver into a two-bank line buffer; read data 1 cycle after i_readAddr. Lines arriving
// with no free bank are dropped and counted. SPI_LINE_INGEST_MSB_FIRST_EN selects MSB-first packing.
module spi_line_ingest
  import lcd_link_pkg::*;
#(
  parameter int WORDS_PER_LINE = LINE_WORDS,
  parameter int WORD_WIDTH     = WORD_BITS,
  parameter int ADDR_WIDTH     = LINE_ADDR_W,
  parameter int SYNC_STAGES    = 2,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_sck,
  input  logic                      i_mosi,
  input  logic                      i_hSync,
  input  logic                      i_vSync,
  input  logic [ADDR_WIDTH-1:0]     i_readAddr,
  output logic [WORD_WIDTH-1:0]     o_readData,
  output logic                      o_lineReady,
  output logic                      o_readBank,
  input  logic                      i_lineDone,
  output logic                      o_frameStart,
  output logic [DROP_CNT_WIDTH-1:0] o_dropCount,
  output logic                      o_overflow
);

  localparam int BIT_W = $clog2(WORD_WIDTH);
  localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(WORD_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS_PER_LINE - 1);

  logic sckLvl, sckRise, mosiLvl, hSyncLvl, vFall;
  logic unusedSckFall, unusedMosiRise, unusedMosiFall;
  logic unusedHRise, unusedHFall, unusedVLvl, unusedVRise;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) uSyncSck (
    .i_clock(i_clock), .i_reset(i_reset), .i_async(i_sck),
    .o_level(sckLvl), .o_rise(sckRise), .o_fall(unusedSckFall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) uSyncMosi (
    .i_clock(i_clock), .i_reset(i_reset), .i_async(i_mosi),
    .o_level(mosiLvl), .o_rise(unusedMosiRise), .o_fall(unusedMosiFall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) uSyncH (
    .i_clock(i_clock), .i_reset(i_reset), .i_async(i_hSync),
    .o_level(hSyncLvl), .o_rise(unusedHRise), .o_fall(unusedHFall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) uSyncV (
    .i_clock(i_clock), .i_reset(i_reset), .i_async(i_vSync),
    .o_level(unusedVLvl), .o_rise(unusedVRise), .o_fall(vFall)
  );

  logic unusedSckLvl;
  assign unusedSckLvl = sckLvl;

  rxState_t state, stateNext;

  logic [BIT_W-1:0]          bitCnt;
  logic [ADDR_WIDTH-1:0]     wordCnt;
  logic [WORD_WIDTH-1:0]     shiftReg;
  logic [WORD_WIDTH-1:0]     fullWord;
  logic [BIT_W-1:0]          bitPos;
  logic                      lineDrop;

  logic                      wrPend;
  logic [ADDR_WIDTH-1:0]     wrAddr;
  logic [WORD_WIDTH-1:0]     wrData;
  logic                      dropLine;

  logic [1:0]                full;
  logic                      wrBank;
  logic                      rdBank;
  logic [DROP_CNT_WIDTH-1:0] dropCount;
  logic                      overflow;
  logic [WORD_WIDTH-1:0]     readData;

  logic [WORD_WIDTH-1:0]     mem0 [WORDS_PER_LINE];
  logic [WORD_WIDTH-1:0]     mem1 [WORDS_PER_LINE];

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= stateNext;
  end

  // A completed line wins over a simultaneous hSync release; a frame sync aborts everything.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (!hSyncLvl) stateNext = RECV;
      RECV: begin
        if (wrPend && (wrAddr == LAST_ADDR)) stateNext = COMMIT;
        else if (hSyncLvl)                  stateNext = IDLE;
      end
      COMMIT:  stateNext = hSyncLvl ? IDLE : RECV;
      default: stateNext = IDLE;
    endcase
    if (vFall) stateNext = IDLE;
  end

  always_comb begin
`ifdef SPI_LINE_INGEST_MSB_FIRST_EN
    bitPos = LAST_BIT - bitCnt;
`else
    bitPos = bitCnt;
`endif
    fullWord         = shiftReg;
    fullWord[bitPos] = mosiLvl;
    lineDrop         = (wordCnt == '0) ? full[wrBank] : dropLine;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bitCnt   <= '0;
      wordCnt  <= '0;
      shiftReg <= '0;
      wrPend   <= 1'b0;
      wrAddr   <= '0;
      wrData   <= '0;
      dropLine <= 1'b0;
    end else begin
      wrPend <= 1'b0;
      if (stateNext == IDLE) begin
        bitCnt  <= '0;
        wordCnt <= '0;
      end else if ((state == RECV) && sckRise) begin
        shiftReg <= fullWord;
        if (bitCnt == LAST_BIT) begin
          bitCnt   <= '0;
          wrPend   <= 1'b1;
          wrAddr   <= wordCnt;
          wrData   <= fullWord;
          dropLine <= lineDrop;
          wordCnt  <= (wordCnt == LAST_ADDR) ? '0 : wordCnt + ADDR_WIDTH'(1);
        end else begin
          bitCnt <= bitCnt + BIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (wrPend && !dropLine) begin
      if (wrBank) mem1[wrAddr] <= wrData;
      else        mem0[wrAddr] <= wrData;
    end
  end

  // Consumer release and producer commit always touch different banks, so both apply.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      full      <= 2'b00;
      wrBank    <= 1'b0;
      rdBank    <= 1'b0;
      dropCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (i_lineDone && full[rdBank]) begin
        full[rdBank] <= 1'b0;
        rdBank       <= ~rdBank;
      end
      if (state == COMMIT) begin
        if (dropLine) begin
          overflow <= 1'b1;
          if (dropCount != '1) dropCount <= dropCount + DROP_CNT_WIDTH'(1);
        end else begin
          full[wrBank] <= 1'b1;
          wrBank       <= ~wrBank;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)                    readData <= '0;
    else if (i_readAddr <= LAST_ADDR) readData <= rdBank ? mem1[i_readAddr] : mem0[i_readAddr];
    else                            readData <= '0;
  end

  assign o_readData   = readData;
  assign o_lineReady  = full[rdBank];
  assign o_readBank   = rdBank;
  assign o_frameStart = vFall;
  assign o_dropCount  = dropCount;
  assign o_overflow   = overflow;

endmodule

// File: doc/spi_line_ingest.md
Name: spi_line_ingest

Overview:
- Upstream stage of the HDP output streamer: receives one LCD line at a time over the host SPI link (i_sck/i_mosi/i_hSync/i_vSync).
- Oversamples the link in the system clock domain and packs bits into 32-bit pixel words.
- Writes each line into a two-bank line buffer and hands completed banks to the streamer through a ready/done handshake plus a registered read port.
- Replaces the i_sck-clocked ingest logic: everything runs on one clock, and buffer ownership is explicit.

Parameters:
- WORDS_PER_LINE, 40, words per line (1280 px / 32).
- WORD_WIDTH, 32, bits per word.
- ADDR_WIDTH, 6, read/write address width; must satisfy 2^ADDR_WIDTH >= WORDS_PER_LINE.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input; minimum 2.
- DROP_CNT_WIDTH, 16, width of the dropped-line counter.

Ports:
- i_clock  in  1  system clock (50 MHz); i_sck must be <= i_clock/4.
- i_reset  in  1  synchronous reset, active-high.
- i_sck  in  1  SPI clock, asynchronous; data is sampled on its rising edge.
- i_mosi  in  1  SPI data, asynchronous.
- i_hSync  in  1  active-low line enable, asynchronous.
- i_vSync  in  1  active-low frame sync, asynchronous.
- i_readAddr  in  ADDR_WIDTH  word index into the ready bank.
- o_readData  out  WORD_WIDTH  registered word from bank o_readBank.
- o_lineReady  out  1  a full bank is available to the consumer.
- o_readBank  out  1  index of the bank the consumer is reading.
- i_lineDone  in  1  one-cycle pulse: consumer has finished with o_readBank.
- o_frameStart  out  1  one-cycle pulse on the synchronized falling edge of i_vSync.
- o_dropCount  out  DROP_CNT_WIDTH  saturating count of discarded lines.
- o_overflow  out  1  sticky flag; set on the first dropped line, cleared only by reset.

Behaviour:
- Reset values:
  - All outputs 0.
  - Both bank-full flags 0; wrBank = 0; rdBank = 0.
  - Bit and word counters 0; synchronizer chains 0.
  - Any partial line is discarded.
  - Reset mid-line discards that line without incrementing o_dropCount.
- Input conditioning:
  - i_sck, i_mosi, i_hSync and i_vSync each pass through SYNC_STAGES flip-flops.
  - sckRise = synchronized sck high AND previous sample low.
  - mosi is sampled from the same synchronizer stage as sck, so setup is preserved.
- Receiver FSM:
  - IDLE: counters held at 0. Go to RECV when synchronized hSync = 0.
  - RECV:
    - On each sckRise, the bit goes into shift position bitCnt (LSB first: bit 0 arrives first).
    - When bitCnt = WORD_WIDTH-1, the assembled word is written to bank wrBank at wordCnt on the next cycle, and bitCnt wraps to 0.
    - If synchronized hSync returns high before the line completes, the partial line is discarded (no flag set, no count change) and the FSM returns to IDLE.
  - COMMIT: entered after word WORDS_PER_LINE-1 is written.
    - Sets full[wrBank] and toggles wrBank.
    - Returns to RECV if hSync is still low, else to IDLE.
    - o_lineReady rises on the cycle after COMMIT.
- Drop rule:
  - If full[wrBank] = 1 when a line's first word completes, the whole line is received but not written.
  - At the line's end: o_dropCount increments (saturating at all-ones), o_overflow is set, wrBank does not toggle.
- Consumer side:
  - o_lineReady = full[rdBank]; o_readBank = rdBank.
  - o_readData has 1-cycle latency from i_readAddr.
  - i_readAddr >= WORDS_PER_LINE returns 0.
  - i_lineDone with o_lineReady = 1: clears full[rdBank] and toggles rdBank.
  - i_lineDone with o_lineReady = 0: ignored.
  - COMMIT and i_lineDone in the same cycle necessarily act on different banks; both take effect.
- o_frameStart pulses on the synchronized vSync falling edge. It also forces the receiver to IDLE (partial line discarded); bank-full flags are untouched.

Optional Feature:
- Macro: SPI_LINE_INGEST_MSB_FIRST_EN.
- Defined: the first received bit lands in bit WORD_WIDTH-1 (MSB first).
- Undefined: LSB first, as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Package lcd_link_pkg holds:
  - constants LINE_WORDS = 40, WORD_BITS = 32, LINE_ADDR_W = 6;
  - the receiver-state enum (IDLE, RECV, COMMIT).
- The HDP streamer shares this package.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall edge detect; one instance per asynchronous input.

Test Plan:
- Two lines, incrementing words 0..39 then 100..139, consumer idle:
  - o_lineReady = 1 with o_readBank = 0.
  - Reads return 0..39; after i_lineDone, o_readBank = 1 and reads return 100..139.
- Single word 0x0000_0001 sent as bit0 = 1 then zeros → word reads 0x0000_0001. Repeat with the MSB_FIRST macro defined → 0x8000_0000.
- Three lines with no i_lineDone:
  - Lines 1 and 2 are stored.
  - Line 3 dropped: o_dropCount = 1, o_overflow = 1, bank contents unchanged.
- i_hSync deasserted after 20 words:
  - No o_lineReady, o_dropCount = 0.
  - The next full line lands in bank 0 intact.
- i_lineDone issued in the same cycle as line 2's COMMIT:
  - Bank 0 freed and bank 1 full; o_lineReady stays 1; o_readBank = 1.
- i_reset asserted mid-word of line 2 → all outputs 0, both banks empty, next line stored in bank 0.
